// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the M-stage / auxiliary requester side and the data-memory arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 32
);
    logic [31:0]       m_instruction;
    logic [31:0]       m_addr;
    logic [31:0]       m_wdata;
    logic              aux_req;
    logic              aux_we;
    logic [ADDR_W-1:0] aux_addr;
    logic [31:0]       aux_wdata;
    logic [31:0]       dmem_q;
    logic              aux_grant;
    logic              aux_rvalid;
    logic [31:0]       aux_rdata;
    logic              cpu_stall;
    logic [31:0]       cpu_rdata;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic              dmem_we;
    logic [CNT_W-1:0]  stall_count;

    modport slave (
        input  m_instruction, m_addr, m_wdata,
        input  aux_req, aux_we, aux_addr, aux_wdata, dmem_q,
        output aux_grant, aux_rvalid, aux_rdata, cpu_stall, cpu_rdata,
        output dmem_addr, dmem_wdata, dmem_we, stall_count
    );

    modport master (
        output m_instruction, m_addr, m_wdata,
        output aux_req, aux_we, aux_addr, aux_wdata, dmem_q,
        input  aux_grant, aux_rvalid, aux_rdata, cpu_stall, cpu_rdata,
        input  dmem_addr, dmem_wdata, dmem_we, stall_count
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-RAM port between the CPU M stage (priority) and an auxiliary
// requester, with a starvation counter that forces the auxiliary side a slot after a bounded wait.
module dmem_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 32
) (
    input logic                 clock,
    input logic                 reset,
    dmem_port_arbiter_if.slave  bus
);
    localparam logic [4:0] OP_SW = 5'b00111;
    localparam logic [4:0] OP_LW = 5'b01000;

    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_AUX} owner_e;

    owner_e            owner;
    logic [4:0]        opcode;
    logic              cpu_req;
    logic              cpu_we;
    logic              force_slot;

    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              aux_rvalid_q, aux_rvalid_d;
    logic [31:0]       aux_rdata_q, aux_rdata_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    // Only the opcode field and the low address bits matter to the port.
    logic unused_bits;
    assign unused_bits = ^{bus.m_instruction[26:0], bus.m_addr[31:ADDR_W]};

    assign opcode     = bus.m_instruction[31:27];
    assign cpu_req    = (opcode == OP_SW) || (opcode == OP_LW);
    assign cpu_we     = (opcode == OP_SW);
    assign force_slot = (starve_cnt_q >= 4'(STARVE_LIMIT));

    always_comb begin
        owner = OWN_NONE;
        if (bus.aux_req && (force_slot || !cpu_req))
            owner = OWN_AUX;
        else if (cpu_req)
            owner = OWN_CPU;
    end

    always_comb begin
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;
        bus.dmem_we    = 1'b0;
        case (owner)
            OWN_CPU: begin
                bus.dmem_addr  = bus.m_addr[ADDR_W-1:0];
                bus.dmem_wdata = bus.m_wdata;
                bus.dmem_we    = cpu_we;
            end
            OWN_AUX: begin
                bus.dmem_addr  = bus.aux_addr;
                bus.dmem_wdata = bus.aux_wdata;
                bus.dmem_we    = bus.aux_we;
            end
            default: ;
        endcase
    end

    assign bus.aux_grant   = (owner == OWN_AUX);
    assign bus.cpu_stall   = cpu_req && (owner != OWN_CPU);
    assign bus.cpu_rdata   = bus.dmem_q;
    assign bus.aux_rvalid  = aux_rvalid_q;
    assign bus.aux_rdata   = aux_rdata_q;
    assign bus.stall_count = stall_count_q;

    always_comb begin
        starve_cnt_d  = starve_cnt_q;
        aux_rvalid_d  = 1'b0;
        aux_rdata_d   = aux_rdata_q;
        stall_count_d = stall_count_q;

        // A grant always clears the wait, so forced slots can never be back to back.
        if (bus.aux_grant)
            starve_cnt_d = 4'd0;
        else if (bus.aux_req && (starve_cnt_q != 4'hF))
            starve_cnt_d = starve_cnt_q + 4'd1;

        if (bus.aux_grant && !bus.aux_we) begin
            aux_rvalid_d = 1'b1;
            aux_rdata_d  = bus.dmem_q;
        end

        if (bus.cpu_stall && (stall_count_q != '1))
            stall_count_d = stall_count_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt_q  <= 4'd0;
            aux_rvalid_q  <= 1'b0;
            aux_rdata_q   <= 32'd0;
            stall_count_q <= '0;
        end else begin
            starve_cnt_q  <= starve_cnt_d;
            aux_rvalid_q  <= aux_rvalid_d;
            aux_rdata_q   <= aux_rdata_d;
            stall_count_q <= stall_count_d;
        end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench: the driver pushes hand-computed expectations per cycle, a monitor pops and
// compares them on the falling edge. Built with CNT_W = 4 so stall_count saturation is reachable.
module tb_dmem_port_arbiter;
    localparam int ADDR_W = 12;
    localparam int CNT_W  = 4;
    localparam logic [31:0] SW  = 32'h3800_0000;
    localparam logic [31:0] LW  = 32'h4000_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct {
        logic        grant;
        logic        stall;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] crdata;
        logic [31:0] sc;
        logic        rvalid;
        logic [31:0] rdata;
    } exp_t;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("aux_grant",   32'(bus.aux_grant),   32'(e.grant));
            chk("cpu_stall",   32'(bus.cpu_stall),   32'(e.stall));
            chk("dmem_we",     32'(bus.dmem_we),     32'(e.we));
            chk("dmem_addr",   32'(bus.dmem_addr),   e.addr);
            chk("dmem_wdata",  bus.dmem_wdata,       e.wdata);
            chk("cpu_rdata",   bus.cpu_rdata,        e.crdata);
            chk("stall_count", 32'(bus.stall_count), e.sc);
            chk("aux_rvalid",  32'(bus.aux_rvalid),  32'(e.rvalid));
            chk("aux_rdata",   bus.aux_rdata,        e.rdata);
        end
    end

    // One cycle: apply inputs just after the rising edge, queue what the falling edge must show.
    task automatic cyc(
        input logic rst, input logic [31:0] ins, maddr, mwd,
        input logic areq, awe, input logic [31:0] aaddr, awd, q,
        input logic g, st, we, input logic [31:0] a, wd, sc,
        input logic rv, input logic [31:0] rd);
        exp_t e;
        @(posedge clock);
        #1;
        reset             = rst;
        bus.m_instruction = ins;
        bus.m_addr        = maddr;
        bus.m_wdata       = mwd;
        bus.aux_req       = areq;
        bus.aux_we        = awe;
        bus.aux_addr      = aaddr[ADDR_W-1:0];
        bus.aux_wdata     = awd;
        bus.dmem_q        = q;
        e.grant = g;  e.stall = st; e.we = we; e.addr = a; e.wdata = wd;
        e.crdata = q; e.sc = sc; e.rvalid = rv; e.rdata = rd;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1;
        bus.m_instruction = NOP; bus.m_addr = 0; bus.m_wdata = 0;
        bus.aux_req = 0; bus.aux_we = 0; bus.aux_addr = 0; bus.aux_wdata = 0; bus.dmem_q = 0;

        // reset state
        cyc(1, NOP, 0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0, 0, 0);
        // CPU-only load
        cyc(0, LW, 32'h10, 32'h1234, 0, 0, 0, 0, 32'hDEADBEEF,
            0, 0, 0, 32'h010, 32'h1234, 0, 0, 0);
        // AUX-only read, rvalid next cycle, then low
        cyc(0, NOP, 0, 0, 1, 0, 32'h2A, 0, 32'hCAFE0001,
            1, 0, 0, 32'h02A, 0, 0, 0, 0);
        cyc(0, NOP, 0, 0, 0, 0, 0, 0, 32'h11111111,  0, 0, 0, 0, 0, 0, 1, 32'hCAFE0001);
        cyc(0, NOP, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0, 0, 32'hCAFE0001);

        // Contention: CPU owns 4 cycles, then a forced aux write slot stalls the sw
        for (int k = 0; k < 4; k++)
            cyc(0, SW, 32'h0000_F100 + k, k, 1, 1, 32'h3F, 5, 0,
                0, 0, 1, 32'h100 + k, k, 0, 0, 32'hCAFE0001);
        cyc(0, SW, 32'h0000_F104, 4, 1, 1, 32'h3F, 5, 0,
            1, 1, 1, 32'h03F, 5, 0, 0, 32'hCAFE0001);
        // no back-to-back forced slot: held sw wins even with aux still requesting
        cyc(0, SW, 32'h0000_F104, 4, 1, 1, 32'h3F, 5, 0,
            0, 0, 1, 32'h104, 4, 1, 0, 32'hCAFE0001);
        // no-op with aux dropped: nothing owns the port, wait count holds at 1
        cyc(0, NOP, 0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 1, 0, 32'hCAFE0001);
        for (int k = 0; k < 3; k++)
            cyc(0, SW, 32'h200 + k, 32'h20 + k, 1, 1, 32'h3F, 5, 0,
                0, 0, 1, 32'h200 + k, 32'h20 + k, 1, 0, 32'hCAFE0001);
        cyc(0, SW, 32'h203, 32'h23, 1, 1, 32'h3F, 5, 0,
            1, 1, 1, 32'h03F, 5, 1, 0, 32'hCAFE0001);
        cyc(0, SW, 32'h203, 32'h23, 0, 0, 0, 0, 0,
            0, 0, 1, 32'h203, 32'h23, 2, 0, 32'hCAFE0001);

        // Reset mid-access: wait count built to 3, then reset during a granted aux read
        for (int k = 0; k < 3; k++)
            cyc(0, SW, 32'h300, 0, 1, 0, 32'h055, 0, 0,
                0, 0, 1, 32'h300, 0, 2, 0, 32'hCAFE0001);
        cyc(0, NOP, 0, 0, 1, 0, 32'h055, 0, 32'h77777777,
            1, 0, 0, 32'h055, 0, 2, 0, 32'hCAFE0001);
        @(negedge clock);
        #2 reset = 1'b1;
        cyc(1, NOP, 0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, SW, 32'h400, 9, 1, 0, 32'h055, 0, 0,   0, 0, 1, 32'h400, 9, 0, 0, 0);
        cyc(0, NOP, 0, 0, 1, 1, 32'h3F, 5, 0,         1, 0, 1, 32'h03F, 5, 0, 0, 0);

        // Saturation: 20 forced-slot stalls into a 4-bit counter
        for (int r = 0; r < 20; r++) begin
            for (int j = 0; j < 5; j++) begin
                if (j < 4)
                    cyc(0, SW, 32'h500, 32'hA, 1, 1, 32'h3F, 5, 0,
                        0, 0, 1, 32'h500, 32'hA, (r > 15) ? 15 : r, 0, 0);
                else
                    cyc(0, SW, 32'h500, 32'hA, 1, 1, 32'h3F, 5, 0,
                        1, 1, 1, 32'h03F, 5, (r > 15) ? 15 : r, 0, 0);
            end
        end
        cyc(0, NOP, 0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 15, 0, 0);

        repeat (2) @(posedge clock);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between the CPU memory stage and one auxiliary requester (I/O / DMA engine).
- CPU has priority. A starvation counter guarantees the auxiliary requester a slot after a bounded wait.
- The arbiter asserts a stall to freeze the pipeline whenever the memory-stage load/store loses the port.
- It sits between the M-stage latch (instruction, ALU address, bypassed store data) and the data RAM.

Parameters:
- ADDR_W, 12, word-address width of the data RAM.
- STARVE_LIMIT, 4, consecutive denied auxiliary-request cycles before the auxiliary requester is forced a slot; legal range 1..15.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- m_instruction  in  32  instruction in the M stage; opcode = [31:27]
- m_addr  in  32  ALU result (word address) for the M-stage access
- m_wdata  in  32  store data after M-stage bypass
- aux_req  in  1  auxiliary access request; held with addr/we/wdata until granted
- aux_we  in  1  1 = auxiliary write, 0 = auxiliary read
- aux_addr  in  ADDR_W  auxiliary word address
- aux_wdata  in  32  auxiliary write data
- dmem_q  in  32  RAM read data, valid in the same cycle as the address
- aux_grant  out  1  auxiliary requester owns the port this cycle
- aux_rvalid  out  1  registered one-cycle pulse: aux_rdata valid
- aux_rdata  out  32  registered auxiliary read data
- cpu_stall  out  1  freeze PC and F/D/X/M latches this cycle
- cpu_rdata  out  32  load data to the M/W latch (= dmem_q)
- dmem_addr  out  ADDR_W  RAM address
- dmem_wdata  out  32  RAM write data
- dmem_we  out  1  RAM write enable
- stall_count  out  CNT_W  saturating count of cpu_stall cycles

Behaviour:
- CPU request: cpu_req = (opcode == 5'b00111 sw) or (opcode == 5'b01000 lw). cpu_we = (opcode == 00111).
- State: starvation counter starve_cnt (4 bits). force = (starve_cnt >= STARVE_LIMIT).
- Owner, combinational each cycle:
  - AUX if aux_req and (force or !cpu_req).
  - Else CPU if cpu_req.
  - Else NONE.
- Port muxing:
  - Owner CPU: dmem_addr = m_addr[ADDR_W-1:0], dmem_wdata = m_wdata, dmem_we = cpu_we.
  - Owner AUX: dmem_addr = aux_addr, dmem_wdata = aux_wdata, dmem_we = aux_we.
  - Owner NONE: dmem_we = 0, dmem_addr = 0, dmem_wdata = 0.
- aux_grant = (owner == AUX).
- cpu_stall = cpu_req and (owner != CPU). The pipeline holds m_instruction and its operands stable while stalled.
- cpu_rdata = dmem_q at all times; it is meaningful only when the owner is CPU and the op is lw.
- starve_cnt update, on the rising edge:
  - Cleared to 0 when aux_grant = 1.
  - Incremented (saturating at 15) when aux_req = 1 and aux_grant = 0.
  - Otherwise held.
- After a forced AUX slot, the counter is 0, so the stalled CPU access wins the next cycle. There are never two forced slots back to back.
- aux_rvalid and aux_rdata, registered:
  - On the edge after a granted auxiliary read (aux_grant and !aux_we): aux_rvalid <= 1 and aux_rdata <= dmem_q.
  - Otherwise aux_rvalid <= 0 and aux_rdata holds its value.
  - Writes produce no rvalid.
- stall_count increments on each edge where cpu_stall = 1 and saturates at all-ones.
- Simultaneous requests without force: CPU wins, the auxiliary requester waits, and starve_cnt increments.
- aux_req dropped before grant: counter holds at its value, no grant is issued, and no error is raised.
- Reset (asynchronous, any time, including mid-access):
  - starve_cnt = 0, aux_rvalid = 0, aux_rdata = 0, stall_count = 0.
  - Combinational outputs follow their inputs immediately.
  - A read granted in the cycle reset asserts yields no rvalid.

Test Plan:
- CPU only: lw at m_addr = 0x0000_0010, dmem_q = 0xDEADBEEF, aux_req = 0 -> dmem_addr = 0x010, dmem_we = 0, cpu_stall = 0, cpu_rdata = 0xDEADBEEF, stall_count stays 0.
- AUX only: aux read at aux_addr = 0x2A, no CPU mem op -> aux_grant = 1 the same cycle; aux_rvalid = 1 next cycle with aux_rdata = dmem_q; rvalid low the cycle after.
- Contention: back-to-back sw every cycle, aux_req held (write 0x5 to 0x3F), STARVE_LIMIT = 4 -> CPU owns 4 cycles, then aux_grant = 1 with cpu_stall = 1 and dmem_we = 1, dmem_addr = 0x3F. The next cycle the CPU sw is granted. stall_count = 1.
- No-op: non-memory opcode (00000) with aux_req = 0 -> dmem_we = 0, no grant, starve_cnt unchanged.
- Reset mid-access: assert reset in the cycle an aux read is granted, with starve_cnt = 3 -> aux_rvalid stays 0, starve_cnt = 0 and stall_count = 0 after release, and the first post-reset simultaneous request goes to the CPU.
- Saturation: preload stall_count near max (CNT_W = 4 build) with 20 stall cycles -> stall_count holds at 0xF.
